// File: rtl/mac_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mac_layer_seq
//  Description : Read sequencer and saturating per-lane accumulator for the
//                64-lane broadcast-weight multiplier array (Q8.8 unsigned).
//                Issues LEN reads from base_addr, aligns the returning lane
//                products with a 2-stage valid pipe, and holds the summed
//                lanes behind a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module mac_layer_seq #(
  parameter int NLANE  = 64,
  parameter int DW     = 16,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     len_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  output logic                  busy_o,
  output logic                  rd_en_o,
  output logic [ADDR_W-1:0]     rd_addr_o,
  input  logic [NLANE*DW-1:0]   prod_flat_i,
  output logic [NLANE*DW-1:0]   result_flat_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  sat_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;       // remaining issue cycles
  logic [ADDR_W-1:0]     addr_q, addr_d;     // current read address
  logic                  drain_q, drain_d;   // second DRAIN cycle marker
  logic [1:0]            vpipe_q, vpipe_d;   // rd_en delayed to product arrival
  logic [NLANE*DW-1:0]   acc_q, acc_d;
  logic                  sat_q, sat_d;

  logic                  w_rd_en;
  logic [NLANE-1:0]      w_ovf;
  logic [NLANE*DW-1:0]   w_acc_upd;

  assign w_rd_en = (state_q == S_ISSUE);

  // Per-lane add at DW+1 bits; a carry out pins the lane at all-ones, which
  // also keeps an already-saturated lane at all-ones for the rest of the job.
  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    logic [DW:0] w_sum;
    assign w_sum = {1'b0, acc_q[i*DW +: DW]} + {1'b0, prod_flat_i[i*DW +: DW]};
    assign w_ovf[i] = w_sum[DW];
    assign w_acc_upd[i*DW +: DW] = w_sum[DW] ? {DW{1'b1}} : w_sum[DW-1:0];
  end

  // Next-state logic: sequencing FSM, address/count, valid pipe, accumulators
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    vpipe_d = {vpipe_q[0], w_rd_en};
    acc_d   = acc_q;
    sat_d   = sat_q;

    // Products arriving while a job runs; a new start below overrides this.
    if (vpipe_q[1]) begin
      acc_d = w_acc_upd;
      sat_d = sat_q | (|w_ovf);
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cnt_d   = len_i;
          addr_d  = base_addr_i;
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = (len_i == '0) ? S_HOLD : S_ISSUE;
        end
      end
      S_ISSUE: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == ADDR_W'(1)) begin
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (result_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset that also flushes the valid pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      drain_q <= 1'b0;
      vpipe_q <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      vpipe_q <= vpipe_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign rd_en_o        = w_rd_en;
  assign rd_addr_o      = addr_q;
  assign result_flat_o  = acc_q;
  assign result_valid_o = (state_q == S_HOLD);
  assign sat_o          = sat_q;

endmodule
`default_nettype wire
